// File: rtl/xor_frame_checksum_if.sv
// Valid/ready word stream in, valid/ready checksum result out, bundled for xor_frame_checksum.
// The DUT uses the slave modport; the word source / result sink uses master.
interface xor_frame_checksum_if #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 5
);
   logic             mode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_parity;
   logic [LEN_W-1:0] out_len;
   logic             out_err;
   logic             out_ovf;

   modport master (
      output mode, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_parity, out_len, out_err, out_ovf
   );

   modport slave (
      input  mode, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_parity, out_len, out_err, out_ovf
   );
endinterface

// File: rtl/xor_frame_checksum.sv
// Streaming XOR checksum: folds a frame's words into a running XOR and reports sum/parity/length.
// Optional saturating error counter port err_cnt when XOR_ERR_CNT_EN is defined.
module xor_frame_checksum_chk #(
   parameter int WIDTH   = 8,
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input logic             clk,
   input logic             rst,
   input logic             in_ready,
   input logic             out_valid,
   input logic             out_ready,
   input logic [WIDTH-1:0] out_sum,
   input logic [LEN_W-1:0] out_len,
   input logic [LEN_W-1:0] len
);
   a_no_input_during_result : assert property (@(posedge clk) disable iff (rst)
      !(in_ready && out_valid));

   a_result_held : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_sum) && $stable(out_len)));

   a_len_bounded : assert property (@(posedge clk) disable iff (rst)
      (32'(len) <= MAX_LEN));
endmodule

module xor_frame_checksum #(
   parameter int WIDTH   = 8,
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   xor_frame_checksum_if.slave  bus
`ifdef XOR_ERR_CNT_EN
   ,
   output logic [15:0]          err_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACC   = 2'd1,
      S_DONE  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);
   localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

   function automatic logic parity_of(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             mode_q, mode_d;
   logic             drain_q, drain_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_sum_q, out_sum_d;
   logic             out_parity_q, out_parity_d;
   logic [LEN_W-1:0] out_len_q, out_len_d;
   logic             out_err_q, out_err_d;
   logic             out_ovf_q, out_ovf_d;
`ifdef XOR_ERR_CNT_EN
   logic [15:0]      err_cnt_q, err_cnt_d;
`endif

   logic             in_ready_s;
   logic             beat_ok_s;
   logic             out_hs_s;
   logic [WIDTH-1:0] fold_acc_s;
   logic [LEN_W-1:0] fold_len_s;
   logic             fold_mode_s;
   logic             finish_s;

   // Handshake qualifiers and the value a beat would fold to in the current state.
   always_comb begin
      in_ready_s  = !rst && (state_q != S_DONE);
      beat_ok_s   = bus.in_valid && in_ready_s;
      out_hs_s    = out_valid_q && bus.out_ready;
      if (state_q == S_IDLE) begin
         fold_acc_s  = bus.in_data;
         fold_len_s  = ONE_L;
         fold_mode_s = bus.mode;
      end else begin
         fold_acc_s  = acc_q ^ bus.in_data;
         fold_len_s  = len_q + ONE_L;
         fold_mode_s = mode_q;
      end
      // A frame ends on its last word or when the length cap is reached.
      finish_s = bus.in_last || (fold_len_s == MAX_LEN_L);
   end

   // Next-state and result capture; results are frozen on entry to DONE.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      len_d        = len_q;
      mode_d       = mode_q;
      drain_d      = drain_q;
      out_valid_d  = out_valid_q;
      out_sum_d    = out_sum_q;
      out_parity_d = out_parity_q;
      out_len_d    = out_len_q;
      out_err_d    = out_err_q;
      out_ovf_d    = out_ovf_q;
      case (state_q)
         S_IDLE, S_ACC: begin
            if (beat_ok_s) begin
               acc_d  = fold_acc_s;
               len_d  = fold_len_s;
               mode_d = fold_mode_s;
               if (finish_s) begin
                  state_d      = S_DONE;
                  out_valid_d  = 1'b1;
                  out_sum_d    = fold_acc_s;
                  out_parity_d = parity_of(fold_acc_s);
                  out_len_d    = fold_len_s;
                  out_err_d    = fold_mode_s && (fold_acc_s != ZERO_W);
                  out_ovf_d    = !bus.in_last;
                  drain_d      = !bus.in_last;
               end else begin
                  state_d = S_ACC;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_DONE: begin
            if (out_hs_s) begin
               out_valid_d = 1'b0;
               state_d     = drain_q ? S_DRAIN : S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DRAIN: begin
            if (beat_ok_s && bus.in_last) begin
               state_d = S_IDLE;
               drain_d = 1'b0;
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            drain_d     = 1'b0;
         end
      endcase
   end

`ifdef XOR_ERR_CNT_EN
   // Saturating count of delivered results that flagged an error or overflow.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (out_hs_s && (out_err_q || out_ovf_q) && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Error counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= 16'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

   // State, accumulator and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         acc_q        <= ZERO_W;
         len_q        <= {LEN_W{1'b0}};
         mode_q       <= 1'b0;
         drain_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         out_sum_q    <= ZERO_W;
         out_parity_q <= 1'b0;
         out_len_q    <= {LEN_W{1'b0}};
         out_err_q    <= 1'b0;
         out_ovf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         len_q        <= len_d;
         mode_q       <= mode_d;
         drain_q      <= drain_d;
         out_valid_q  <= out_valid_d;
         out_sum_q    <= out_sum_d;
         out_parity_q <= out_parity_d;
         out_len_q    <= out_len_d;
         out_err_q    <= out_err_d;
         out_ovf_q    <= out_ovf_d;
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_sum    = out_sum_q;
   assign bus.out_parity = out_parity_q;
   assign bus.out_len    = out_len_q;
   assign bus.out_err    = out_err_q;
   assign bus.out_ovf    = out_ovf_q;

   xor_frame_checksum_chk #(
      .WIDTH   (WIDTH),
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .in_ready  (in_ready_s),
      .out_valid (out_valid_q),
      .out_ready (bus.out_ready),
      .out_sum   (out_sum_q),
      .out_len   (out_len_q),
      .len       (len_q)
   );

endmodule
